mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Sequences and shares the single 4-cycle main memory between three requesters:
  - instruction-cache block fill,
  - data-cache block fill,
  - data store write-through.
- Sits between the I/D cache arrays and the memory instance, replacing the per-cache fill FSM.
- Grants one requester at a time.
- Generates the 8-word burst addresses and steers returning words into the owning cache.
- Emits done pulses and stall flags back to the pipeline.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data word width
WORDS, 8, words per cache block (power of 2; word stride 2 bytes)

Ports:
clk  in  1  clock (rising edge)
rst  in  1  asynchronous active-high reset
i_req  in  1  I-cache miss; level, held until i_done
i_addr  in  ADDR_W  I-cache miss address
d_req  in  1  D-cache miss; level, held until d_done
d_addr  in  ADDR_W  D-cache miss address
st_req  in  1  store write-through request; level, held until st_ack
st_addr  in  ADDR_W  store address
st_data  in  DATA_W  store data
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_enable  out  1  memory access strobe
mem_wr  out  1  memory write strobe
mem_rdata  in  DATA_W  memory read data
mem_valid  in  1  memory read data valid
fill_data  out  DATA_W  word to write into cache
fill_word  out  3  word index within block (log2 WORDS)
fill_we_i  out  1  write fill_data into I-cache
fill_we_d  out  1  write fill_data into D-cache
i_done  out  1  one-cycle pulse: I fill complete
d_done  out  1  one-cycle pulse: D fill complete
st_ack  out  1  one-cycle pulse: store issued
f_stall  out  1  fetch stall
m_stall  out  1  memory-stage stall
busy  out  1  arbiter not IDLE

Behaviour:
- Reset values (asynchronous, all outputs and state):
  - state = IDLE; issue_cnt = 0; recv_cnt = 0; base = 0.
  - All strobes and pulses = 0; mem_addr = 0, mem_wdata = 0, fill_data = 0, fill_word = 0.
- State IDLE:
  - Fixed priority: i_req, then d_req, then st_req.
  - Winner: base <= {addr[ADDR_W-1:4], 4'b0}; owner <= I/D. Store winner goes to STORE instead.
  - Grant decision is made in the IDLE cycle; the first access happens the following cycle.
- State FILL:
  - Issue phase, while issue_cnt < WORDS:
    - mem_enable = 1, mem_wr = 0, mem_addr = base + 2*issue_cnt.
    - issue_cnt increments every cycle.
  - Receive phase, on each mem_valid:
    - fill_data = mem_rdata, fill_word = recv_cnt.
    - fill_we_i = 1 if owner = I, else fill_we_d = 1.
    - recv_cnt increments.
  - Issue and receive overlap.
  - After the WORDS-th valid, go to DONE.
- State DONE (1 cycle):
  - i_done or d_done = 1 according to owner.
  - Counters cleared; go to IDLE.
  - The requester drops req the next cycle, so the IDLE cycle after DONE ignores the stale req of the owner just served.
- State STORE (1 cycle):
  - mem_enable = 1, mem_wr = 1, mem_addr = st_addr, mem_wdata = st_data, st_ack = 1.
  - Go to IDLE.
- mem_valid is ignored outside FILL and once recv_cnt = WORDS (no fill strobe, no count).
- Requests arriving during a busy period wait. Addresses are sampled only at grant; changes after grant are ignored.
- Stall flags:
  - f_stall = i_req & ~i_done.
  - m_stall = (d_req & ~d_done) | (st_req & ~st_ack).
- busy = (state != IDLE).
- fill_word wraps with recv_cnt[2:0]. base is block-aligned, so addresses never cross the block.
- Async rst mid-burst: immediate return to IDLE and counters cleared. Returning memory data is dropped.
- Latency, MEM_LAT = 4, grant at cycle t:
  - Issues at t+1..t+8.
  - Valids at t+5..t+12.
  - Done at t+13.
  - Store: st_ack at t+1.

Optional Feature:
- Macro ARB_RR_EN.
- Defined:
  - IDLE arbitration is round-robin among {I, D, ST}.
  - A last-served pointer (reset = ST, so I wins first) rotates to the class after the one just granted.
  - A requester waits at most two other grants.
- Undefined: fixed priority I > D > ST as above; no pointer register.

Test Plan:
- I miss alone:
  - Stimulus: i_req = 1, i_addr = 0x1236 at cycle 0; memory returns 0xA000+n for word n.
  - Required: mem_addr 0x1230, 0x1232, …, 0x123E on cycles 1-8; fill_we_i with fill_word 0-7 and data 0xA000-0xA007 on cycles 5-12; i_done on cycle 13; f_stall high on cycles 0-12.
- Simultaneous requests:
  - Stimulus: i_req, d_req (0x4000) and st_req (0x5002, 0xBEEF) at cycle 0.
  - Required without ARB_RR_EN: I fill, then D fill, then store write at 0x5002 with mem_wr = 1 and st_ack.
  - Required with ARB_RR_EN: same order from reset; after a further I request arriving during the D fill, the store is granted before it.
- Store only:
  - Stimulus: st_req, st_addr = 0x0010, st_data = 0x1234.
  - Required: cycle 1 mem_enable = mem_wr = 1; st_ack pulse; busy back to 0 on cycle 2.
- Spurious valid:
  - Stimulus: mem_valid pulsed in IDLE and during STORE.
  - Required: no fill_we_*; counters remain 0.
- Reset mid-burst:
  - Stimulus: rst asserted during cycle 7 of a D fill.
  - Required: all outputs 0 immediately; subsequent valids ignored; new i_req afterwards completes a normal 8-word fill.
- Address change after grant:
  - Stimulus: d_addr changed from 0x2000 to 0x3000 on cycle 3 of a fill.
  - Required: all issued addresses stay 0x2000-0x200E.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles every signal that passes between mem_port_arbiter and the blocks
// around it: the three requesters (I-cache fill, D-cache fill, store
// write-through), the 4-cycle main memory, the cache fill write port and the
// pipeline stall/status flags.
//
// Modports:
//   slave  - the arbiter side: takes requests and memory read data, and
//            drives the memory strobes, fill port, done pulses and stalls.
//   master - the environment side (caches, pipeline, memory), mirror image.
//
// Parameters:
//   ADDR_W - address width
//   DATA_W - data word width
//   WORDS  - words per cache block (power of 2, at least 2)
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int WORDS  = 8
);
  localparam int WL = $clog2(WORDS);

  // requesters
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic              st_req;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;

  // main memory
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_enable;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_valid;

  // cache fill write port
  logic [DATA_W-1:0] fill_data;
  logic [WL-1:0]     fill_word;
  logic              fill_we_i;
  logic              fill_we_d;

  // completion pulses and pipeline flags
  logic              i_done;
  logic              d_done;
  logic              st_ack;
  logic              f_stall;
  logic              m_stall;
  logic              busy;

  modport slave (
    input  i_req, i_addr, d_req, d_addr, st_req, st_addr, st_data,
    input  mem_rdata, mem_valid,
    output mem_addr, mem_wdata, mem_enable, mem_wr,
    output fill_data, fill_word, fill_we_i, fill_we_d,
    output i_done, d_done, st_ack, f_stall, m_stall, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_addr, st_req, st_addr, st_data,
    output mem_rdata, mem_valid,
    input  mem_addr, mem_wdata, mem_enable, mem_wr,
    input  fill_data, fill_word, fill_we_i, fill_we_d,
    input  i_done, d_done, st_ack, f_stall, m_stall, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares the single main memory (fixed 4-cycle read latency) between the
// I-cache block fill, the D-cache block fill and the store write-through.
// One requester is granted at a time. A fill issues WORDS consecutive word
// reads of the block while the returning words are steered into the owning
// cache; a store is a single write cycle. Done/ack pulses and stall flags go
// back to the pipeline.
//
// Ports:
//   clk - clock, rising edge
//   rst - asynchronous active-high reset
//   bus - mem_port_arbiter_if.slave: requests, memory port, fill port,
//         done/ack pulses, f_stall / m_stall / busy
//
// Build option:
//   ARB_RR_EN - when defined, IDLE arbitration is round-robin over {I, D, ST}
//               using a last-served pointer. When undefined, fixed priority
//               I > D > ST and no pointer register exists.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int WORDS  = 8
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam int WL = $clog2(WORDS);
  // counters must reach WORDS itself, hence one extra bit
  localparam int CW = WL + 1;
  // byte offset bits inside a block (2-byte word stride)
  localparam int OW = WL + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(WORDS);
  localparam logic [CW-1:0] CNT_LAST = CW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE,
    STORE
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     issue_q, issue_d;
  logic [CW-1:0]     recv_q, recv_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              owner_i_q, owner_i_d;
  logic [2:0]        mask_q, mask_d;

  logic [2:0]        req_elig;
  logic [2:0]        grant;

  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_wdata_c;
  logic              mem_enable_c;
  logic              mem_wr_c;
  logic [DATA_W-1:0] fill_data_c;
  logic [WL-1:0]     fill_word_c;
  logic              fill_we_i_c;
  logic              fill_we_d_c;
  logic              i_done_c;
  logic              d_done_c;
  logic              st_ack_c;

  function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:OW], {OW{1'b0}}};
  endfunction

  // A requester keeps its req high for one cycle after its done/ack pulse,
  // so the class just served is masked for the IDLE cycle that follows.
  assign req_elig = {bus.st_req, bus.d_req, bus.i_req} & ~mask_q;

`ifdef ARB_RR_EN
  typedef enum logic [1:0] {
    CLS_I,
    CLS_D,
    CLS_ST
  } cls_e;

  cls_e last_q, last_d;

  // Round-robin: search starts at the class after the one served last.
  always_comb begin
    grant = 3'b000;
    case (last_q)
      CLS_I: begin
        if (req_elig[1])      grant = 3'b010;
        else if (req_elig[2]) grant = 3'b100;
        else if (req_elig[0]) grant = 3'b001;
      end
      CLS_D: begin
        if (req_elig[2])      grant = 3'b100;
        else if (req_elig[0]) grant = 3'b001;
        else if (req_elig[1]) grant = 3'b010;
      end
      default: begin
        if (req_elig[0])      grant = 3'b001;
        else if (req_elig[1]) grant = 3'b010;
        else if (req_elig[2]) grant = 3'b100;
      end
    endcase
  end

  // The pointer moves only when a grant is actually taken in IDLE.
  always_comb begin
    last_d = last_q;
    if (state_q == IDLE) begin
      if (grant[0])      last_d = CLS_I;
      else if (grant[1]) last_d = CLS_D;
      else if (grant[2]) last_d = CLS_ST;
    end
  end

  // Starts at ST so that I wins the first arbitration after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= CLS_ST;
    end else begin
      last_q <= last_d;
    end
  end
`else
  // Fixed priority: instruction fill, then data fill, then store.
  always_comb begin
    grant = 3'b000;
    if (req_elig[0])      grant = 3'b001;
    else if (req_elig[1]) grant = 3'b010;
    else if (req_elig[2]) grant = 3'b100;
  end
`endif

  // Next-state and output decode. Issue and receive run independently in
  // FILL: reads go out back to back while earlier words are still coming
  // back, and the block is finished by the last returning word.
  always_comb begin
    state_d      = state_q;
    issue_d      = issue_q;
    recv_d       = recv_q;
    base_d       = base_q;
    owner_i_d    = owner_i_q;
    mask_d       = mask_q;
    mem_addr_c   = '0;
    mem_wdata_c  = '0;
    mem_enable_c = 1'b0;
    mem_wr_c     = 1'b0;
    fill_data_c  = '0;
    fill_word_c  = '0;
    fill_we_i_c  = 1'b0;
    fill_we_d_c  = 1'b0;
    i_done_c     = 1'b0;
    d_done_c     = 1'b0;
    st_ack_c     = 1'b0;

    case (state_q)
      IDLE: begin
        mask_d = 3'b000;
        if (grant[0]) begin
          state_d   = FILL;
          owner_i_d = 1'b1;
          base_d    = block_base(bus.i_addr);
        end else if (grant[1]) begin
          state_d   = FILL;
          owner_i_d = 1'b0;
          base_d    = block_base(bus.d_addr);
        end else if (grant[2]) begin
          state_d = STORE;
        end
      end

      FILL: begin
        if (issue_q < CNT_FULL) begin
          mem_enable_c = 1'b1;
          mem_addr_c   = base_q | {{(ADDR_W-OW){1'b0}}, issue_q[WL-1:0], 1'b0};
          issue_d      = issue_q + 1'b1;
        end
        if (bus.mem_valid && (recv_q < CNT_FULL)) begin
          fill_data_c = bus.mem_rdata;
          fill_word_c = recv_q[WL-1:0];
          fill_we_i_c = owner_i_q;
          fill_we_d_c = ~owner_i_q;
          recv_d      = recv_q + 1'b1;
          if (recv_q == CNT_LAST) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        i_done_c = owner_i_q;
        d_done_c = ~owner_i_q;
        issue_d  = '0;
        recv_d   = '0;
        mask_d   = owner_i_q ? 3'b001 : 3'b010;
        state_d  = IDLE;
      end

      STORE: begin
        mem_enable_c = 1'b1;
        mem_wr_c     = 1'b1;
        mem_addr_c   = bus.st_addr;
        mem_wdata_c  = bus.st_data;
        st_ack_c     = 1'b1;
        mask_d       = 3'b100;
        state_d      = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any burst in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      issue_q   <= '0;
      recv_q    <= '0;
      base_q    <= '0;
      owner_i_q <= 1'b0;
      mask_q    <= 3'b000;
    end else begin
      state_q   <= state_d;
      issue_q   <= issue_d;
      recv_q    <= recv_d;
      base_q    <= base_d;
      owner_i_q <= owner_i_d;
      mask_q    <= mask_d;
    end
  end

  assign bus.mem_addr   = mem_addr_c;
  assign bus.mem_wdata  = mem_wdata_c;
  assign bus.mem_enable = mem_enable_c;
  assign bus.mem_wr     = mem_wr_c;
  assign bus.fill_data  = fill_data_c;
  assign bus.fill_word  = fill_word_c;
  assign bus.fill_we_i  = fill_we_i_c;
  assign bus.fill_we_d  = fill_we_d_c;
  assign bus.i_done     = i_done_c;
  assign bus.d_done     = d_done_c;
  assign bus.st_ack     = st_ack_c;
  assign bus.f_stall    = bus.i_req & ~i_done_c;
  assign bus.m_stall    = (bus.d_req & ~d_done_c) | (bus.st_req & ~st_ack_c);
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Drives the arbiter through directed scenarios (single I miss, simultaneous
// requests and grant order, store with stray valids, late address change,
// reset in the middle of a D fill) and a randomized phase. A 4-cycle memory
// answers the reads the arbiter issues. Expected outputs for every cycle come
// from a transaction-level model: each grant opens a timeline measured from
// the grant cycle (issues at +1..+8, words at +5..+12, done at +13; store at
// +1), and arbitration is a priority search over the waiting requesters.
// Define ARB_RR_EN for the bench and the design together.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 16;
  localparam int WORDS   = 8;
  localparam int MEM_LAT = 4;
  localparam int CI = 0;
  localparam int CD = 1;
  localparam int CS = 2;

  logic clk;
  logic rst;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS(WORDS)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS(WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int totalCnt = 0;
  int badCnt   = 0;
  int cyc      = 0;

  // requester side
  bit          reqV[3];
  logic [15:0] reqAddr[3];
  logic [15:0] stData;
  int          doneAt[3];
  bit          rstDrive;

  // memory side
  int          pipeCyc[$];
  logic [15:0] pipeAddr[$];
  bit          memDirected;
  bit          spurEn;
  bit          randReq;

  // reference model
  bit          mActive;
  int          mKind;
  int          mGrant;
  int          mLast;
  int          mMaskCls;
  int          mMaskCyc;
  logic [15:0] mBase;

  // expected outputs for the current cycle
  logic        eEn, eWr, eWeI, eWeD, eIdone, eDdone, eAck, eBusy, eF, eM;
  logic [15:0] eAddr, eWdata, eFd;
  logic [2:0]  eFw;

  // completion order log
  bit          logEn;
  logic [31:0] seqObs;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalCnt++;
    if (got !== exp) begin
      badCnt++;
      $display("[TB] FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [15:0] memFn(input logic [15:0] a);
    if (memDirected) return 16'hA000 + {13'd0, a[3:1]};
    return 16'(a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  function automatic bit fillWindow();
    int d;
    d = cyc - mGrant;
    return mActive && (mKind != CS) && (d >= 1) && (d <= 12);
  endfunction

  task automatic raise(input int c, input logic [15:0] a, input logic [15:0] dt);
    reqV[c]    = 1'b1;
    reqAddr[c] = a;
    if (c == CS) stData = dt;
  endtask

  // Drives the requester lines and the memory return for cycle 'cyc'.
  task automatic applyStimulus();
    rst = rstDrive;
    for (int c = 0; c < 3; c++) begin
      if (rstDrive) begin
        reqV[c]   = 1'b0;
        doneAt[c] = -1;
      end else if (reqV[c] && doneAt[c] >= 0 && cyc >= doneAt[c] + ((c == CS) ? 1 : 2)) begin
        reqV[c]   = 1'b0;
        doneAt[c] = -1;
      end else if (randReq && !reqV[c] && $urandom_range(7) == 0) begin
        reqV[c]    = 1'b1;
        reqAddr[c] = 16'($urandom);
        if (c == CS) stData = 16'($urandom);
      end else if (randReq && reqV[c] && c != CS && $urandom_range(15) == 0) begin
        reqAddr[c] = 16'($urandom);
      end
    end
    bus.i_req   = reqV[CI];
    bus.i_addr  = reqAddr[CI];
    bus.d_req   = reqV[CD];
    bus.d_addr  = reqAddr[CD];
    bus.st_req  = reqV[CS];
    bus.st_addr = reqAddr[CS];
    bus.st_data = stData;

    bus.mem_valid = 1'b0;
    bus.mem_rdata = '0;
    if (pipeCyc.size() > 0 && pipeCyc[0] == cyc) begin
      bus.mem_valid = 1'b1;
      bus.mem_rdata = memFn(pipeAddr[0]);
      void'(pipeCyc.pop_front());
      void'(pipeAddr.pop_front());
    end else if (spurEn && !fillWindow() && $urandom_range(3) == 0) begin
      bus.mem_valid = 1'b1;
      bus.mem_rdata = 16'($urandom);
    end
  endtask

  // Reference model for cycle 'cyc'.
  task automatic modelStep();
    int d;
    int pick;
    int c;
    bit elig[3];
    eEn = 0; eWr = 0; eWeI = 0; eWeD = 0; eIdone = 0; eDdone = 0; eAck = 0; eBusy = 0;
    eAddr = '0; eWdata = '0; eFd = '0; eFw = '0;
    if (rst) begin
      mActive  = 0;
      mLast    = CS;
      mMaskCyc = -1;
    end else if (mActive) begin
      d = cyc - mGrant;
      eBusy = 1;
      if (mKind == CS) begin
        eEn = 1; eWr = 1; eAck = 1;
        eAddr  = reqAddr[CS];
        eWdata = stData;
        doneAt[CS] = cyc;
        mActive = 0;
      end else begin
        if (d >= 1 && d <= WORDS) begin
          eEn   = 1;
          eAddr = 16'(mBase + 2 * (d - 1));
        end
        if (d >= 1 + MEM_LAT && d <= WORDS + MEM_LAT) begin
          eWeI = (mKind == CI);
          eWeD = (mKind == CD);
          eFw  = 3'(d - 1 - MEM_LAT);
          eFd  = memFn(16'(mBase + 2 * (d - 1 - MEM_LAT)));
        end
        if (d == WORDS + MEM_LAT + 1) begin
          eIdone = (mKind == CI);
          eDdone = (mKind == CD);
          doneAt[mKind] = cyc;
          mMaskCls = mKind;
          mMaskCyc = cyc + 1;
          mActive = 0;
        end
      end
    end else begin
      for (int k = 0; k < 3; k++) elig[k] = reqV[k] && !(mMaskCyc == cyc && mMaskCls == k);
      pick = -1;
      for (int k = 1; k <= 3; k++) begin
`ifdef ARB_RR_EN
        c = (mLast + k) % 3;
`else
        c = k - 1;
`endif
        if (pick < 0 && elig[c]) pick = c;
      end
      if (pick >= 0) begin
        mActive = 1;
        mKind   = pick;
        mGrant  = cyc;
        mBase   = reqAddr[pick] & 16'hFFF0;
        mLast   = pick;
      end
    end
    eF = reqV[CI] && !eIdone;
    eM = (reqV[CD] && !eDdone) || (reqV[CS] && !eAck);
  endtask

  task automatic compareCycle();
    logic [31:0] ctrlGot;
    logic [31:0] ctrlExp;
    ctrlGot = {22'd0, bus.mem_enable, bus.mem_wr, bus.fill_we_i, bus.fill_we_d, bus.i_done,
               bus.d_done, bus.st_ack, bus.busy, bus.f_stall, bus.m_stall};
    ctrlExp = {22'd0, eEn, eWr, eWeI, eWeD, eIdone, eDdone, eAck, eBusy, eF, eM};
    checkOutput("ctrl", ctrlGot, ctrlExp);
    checkOutput("mem_addr", {16'd0, bus.mem_addr}, {16'd0, eAddr});
    checkOutput("mem_wdata", {16'd0, bus.mem_wdata}, {16'd0, eWdata});
    checkOutput("fill_data", {16'd0, bus.fill_data}, {16'd0, eFd});
    checkOutput("fill_word", {29'd0, bus.fill_word}, {29'd0, eFw});
    if (logEn) begin
      if (bus.i_done === 1'b1) seqObs = (seqObs << 4) | 32'd1;
      if (bus.d_done === 1'b1) seqObs = (seqObs << 4) | 32'd2;
      if (bus.st_ack === 1'b1) seqObs = (seqObs << 4) | 32'd3;
    end
    if (bus.mem_enable === 1'b1 && bus.mem_wr === 1'b0) begin
      pipeCyc.push_back(cyc + MEM_LAT);
      pipeAddr.push_back(bus.mem_addr);
    end
  endtask

  task automatic runCycle();
    @(posedge clk);
    #1;
    applyStimulus();
    modelStep();
    @(negedge clk);
    compareCycle();
    cyc++;
  endtask

  // Runs until the model and requesters are quiet, within a cycle budget.
  task automatic drain(input int budget);
    bit pending;
    pending = 1;
    for (int k = 0; k < budget && pending; k++) begin
      runCycle();
      pending = mActive || reqV[CI] || reqV[CD] || reqV[CS];
    end
    checkOutput("drain", {31'd0, pending}, 32'd0);
  endtask

  initial begin
    bit reRaised;
    bit hit;
    logic [31:0] seqExp;
    for (int c = 0; c < 3; c++) begin
      reqV[c] = 0; reqAddr[c] = '0; doneAt[c] = -1;
    end
    stData = '0; memDirected = 1; spurEn = 0; randReq = 0; logEn = 0; seqObs = '0;
    mActive = 0; mKind = 0; mGrant = 0; mLast = CS; mMaskCls = -1; mMaskCyc = -1; mBase = '0;
    rst = 1'b1; rstDrive = 1;
    bus.i_req = 0; bus.i_addr = '0; bus.d_req = 0; bus.d_addr = '0;
    bus.st_req = 0; bus.st_addr = '0; bus.st_data = '0;
    bus.mem_valid = 0; bus.mem_rdata = '0;

    $display("[TB] reset");
    repeat (2) runCycle();
    rstDrive = 0;
    runCycle();

    $display("[TB] I miss alone");
    raise(CI, 16'h1236, 16'h0000);
    drain(40);

    $display("[TB] simultaneous requests");
    logEn = 1; seqObs = '0; reRaised = 0;
    raise(CI, 16'h0100, 16'h0000);
    raise(CD, 16'h4000, 16'h0000);
    raise(CS, 16'h5002, 16'hBEEF);
    for (int k = 0; k < 90; k++) begin
      if (!reRaised && mActive && mKind == CD && !reqV[CI] && doneAt[CI] < 0) begin
        raise(CI, 16'h0200, 16'h0000);
        reRaised = 1;
      end
      runCycle();
    end
    logEn = 0;
`ifdef ARB_RR_EN
    seqExp = 32'h1231;
`else
    seqExp = 32'h1213;
`endif
    checkOutput("grant_order", seqObs, seqExp);

    $display("[TB] store only with stray valids");
    spurEn = 1;
    raise(CS, 16'h0010, 16'h1234);
    drain(10);
    repeat (8) runCycle();

    $display("[TB] address change after grant");
    raise(CD, 16'h2000, 16'h0000);
    repeat (3) runCycle();
    reqAddr[CD] = 16'h3000;
    drain(40);

    $display("[TB] randomized traffic");
    memDirected = 0;
    randReq = 1;
    repeat (800) runCycle();
    randReq = 0;
    drain(200);

    $display("[TB] reset mid-burst");
    raise(CD, 16'h6788, 16'h0000);
    hit = 0;
    for (int k = 0; k < 30 && !hit; k++) begin
      if (mActive && mKind == CD && cyc - mGrant == 7) hit = 1;
      else runCycle();
    end
    checkOutput("rst_reach", {31'd0, hit}, 32'd1);
    rstDrive = 1;
    repeat (2) runCycle();
    rstDrive = 0;
    repeat (6) runCycle();
    raise(CI, 16'h7770, 16'h0000);
    drain(40);

    $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
